seq_div: RTL
============

# seq_div

Iterative unsigned restoring divider with fixed latency. It produces a `WIDTH`-bit quotient and remainder, one quotient bit per cycle. It is the sequential counterpart to the combinational arithmetic primitives (`Add`, `Sub`, `MultComb`, comparators). Its operands come from combinational datapath logic, and its registered results feed back into that logic. Its fixed start-to-done latency lets schedulers treat it as a pipeline stage of known length.

## Interface
- `WIDTH`, default 32: operand and result width in bits; legal range 2 to 64.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-low; sampled on the `clk` rising edge; low clears all state.
- `go`  input  1  start request; sampled on the rising edge; honoured only in IDLE or DONE.
- `left`  input  `WIDTH`  dividend; sampled on the edge that accepts `go`.
- `right`  input  `WIDTH`  divisor; sampled on the edge that accepts `go`.
- `quotient`  output  `WIDTH`  registered result; holds its value until the next result is written.
- `remainder`  output  `WIDTH`  registered result; holds its value until the next result is written.
- `done`  output  1  high for exactly one cycle when a new result is on the outputs.
- `busy`  output  1  high while in RUN.
- `div_by_zero`  output  1  registered flag written with each result: 1 if that operation's `right` was 0.

## Operation
- States: IDLE, RUN, DONE.
- Internal registers:
  - `R`: partial remainder, `WIDTH+1` bits.
  - `Q`: dividend/quotient shift register, `WIDTH` bits.
  - `D`: latched divisor, `WIDTH` bits.
  - `cnt`: iteration counter, ceil(log2(`WIDTH`+1)) bits.
- IDLE or DONE with `go`=1:
  - Load `Q`=`left`, `D`=`right`, `R`=0, `cnt`=0.
  - Latch zero flag = (`right`==0).
  - Next state RUN.
- IDLE with `go`=0: remain in IDLE.
- DONE with `go`=0: next state IDLE.
- RUN, each cycle:
  - Form `S` = {`R`[`WIDTH`-1:0], `Q`[`WIDTH`-1]}, `WIDTH+1` bits.
  - Form `T` = `S` − {0,`D`}.
  - If `T` is non-negative (MSB 0): `R`=`T` and `Q`={`Q`[`WIDTH`-2:0],1}.
  - Otherwise: `R`=`S` and `Q`={`Q`[`WIDTH`-2:0],0}.
  - `cnt`+=1.
- RUN exit: when `cnt`==`WIDTH`-1 this cycle, that edge performs the final iteration and also:
  - writes `quotient` = final `Q` and `remainder` = final `R`[`WIDTH`-1:0];
  - writes `div_by_zero`;
  - moves to DONE.
- `go` in RUN is ignored; the operation in flight is not disturbed.
- Divide by zero uses no special path. The algorithm naturally yields `quotient` = all ones and `remainder` = `left`, at the same latency, with `div_by_zero`=1.
- `done` = (state==DONE). `busy` = (state==RUN).
- Reset (`reset`=0 at an edge, any state, including mid-RUN):
  - state IDLE;
  - `quotient`=0, `remainder`=0, `div_by_zero`=0, `done`=0, `busy`=0;
  - the in-flight operation is discarded and produces no `done`.
- Reset takes priority over `go` on the same edge.

## Timing
- Let `go` be accepted on edge E.
- `busy` is high from E through E+`WIDTH`; it goes low when DONE is entered.
- Iterations occur on edges E+1 through E+`WIDTH`.
- Results, `div_by_zero` and `done`=1 are visible in the cycle after edge E+`WIDTH`. Latency is exactly `WIDTH` cycles, independent of operand values.
- `done` drops after edge E+`WIDTH`+1 unless `go` is accepted there.
- Back-to-back: `go` accepted in DONE (edge E+`WIDTH`+1) starts the next operation with no idle cycle. Throughput is one result per `WIDTH`+1 cycles.
- Results remain stable from the DONE cycle until the edge that writes the next result. Accepting a new `go` does not clear them.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
All scenarios use `WIDTH`=8.
- Basic divide: `left`=100, `right`=7, `go` for 1 cycle → `done`=1 exactly 8 cycles after the accepting edge, with `quotient`=14, `remainder`=2, `div_by_zero`=0; `done` low on the following cycle.
- Boundary operands:
  - 255/1 → `quotient`=255, `remainder`=0.
  - 5/9 → `quotient`=0, `remainder`=5.
  - 255/255 → `quotient`=1, `remainder`=0.
  - Each at 8-cycle latency.
- Divide by zero: `left`=77, `right`=0 → `quotient`=255, `remainder`=77, `div_by_zero`=1, same latency.
- Ignored go: `go` pulsed with 50/5 at cycle 0, then again with 9/3 at cycle 3 → single `done` at cycle 8 with `quotient`=10, `remainder`=0; no second `done`.
- Back-to-back: 200/3, then `go` with 17/4 held high during the DONE cycle →
  - first `done` shows `quotient`=66, `remainder`=2;
  - `busy` is high the next cycle;
  - second `done` 9 cycles after the first shows `quotient`=4, `remainder`=1;
  - the first results hold until then.
- Reset mid-operation: start 100/7, drive `reset`=0 at cycle 4 for 1 cycle → all outputs 0, no `done`. Then 60/8 started afterwards → `quotient`=7, `remainder`=4 at normal latency.

Source files
------------

// File: rtl/seq_div_if.sv
// Operand/result bundle for the sequential divider.
interface seq_div_if #(
  parameter int unsigned WIDTH = 32
);
  logic             go;
  logic [WIDTH-1:0] left;
  logic [WIDTH-1:0] right;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             busy;
  logic             div_by_zero;

  modport master (
    output go, left, right,
    input  quotient, remainder, done, busy, div_by_zero
  );

  modport slave (
    input  go, left, right,
    output quotient, remainder, done, busy, div_by_zero
  );
endinterface

// File: rtl/seq_div.sv
// Iterative unsigned restoring divider: one quotient bit per cycle,
// WIDTH-cycle fixed latency, registered results.
module seq_div #(
  parameter int unsigned WIDTH = 32
) (
  input logic      clk,
  input logic      reset,
  seq_div_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  // Partial remainder kept WIDTH bits wide: after every restore step its top
  // bit is zero, so only the low bits ever feed the next trial subtract.
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    cnt;
  logic             zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             dbz;

  logic [WIDTH:0]   s;
  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] r_nx;
  logic [WIDTH-1:0] q_nx;
  logic             accept;
  logic             last;

  // One restoring step: shift in the next dividend bit, trial-subtract.
  always_comb begin
    s    = {r, q[WIDTH-1]};
    t    = s - {1'b0, d};
    r_nx = t[WIDTH] ? s[WIDTH-1:0] : t[WIDTH-1:0];
    q_nx = {q[WIDTH-2:0], ~t[WIDTH]};
  end

  // Next-state logic; go only counts outside RUN.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    last     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.go) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(WIDTH - 1)) begin
          last     = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (bus.go) begin
          accept   = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Operand load, iteration and result write-back.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r         <= '0;
      q         <= '0;
      d         <= '0;
      cnt       <= '0;
      zero      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else if (accept) begin
      r    <= '0;
      q    <= bus.left;
      d    <= bus.right;
      cnt  <= '0;
      zero <= (bus.right == '0);
    end else if (state == RUN) begin
      r   <= r_nx;
      q   <= q_nx;
      cnt <= cnt + CW'(1);
      if (last) begin
        quotient  <= q_nx;
        remainder <= r_nx;
        dbz       <= zero;
      end
    end
  end

  assign bus.quotient    = quotient;
  assign bus.remainder   = remainder;
  assign bus.div_by_zero = dbz;
  assign bus.done        = (state == DONE);
  assign bus.busy        = (state == RUN);

endmodule
